// File: rtl/snn_readout_pkg.sv
// -----------------------------------------------------------------------------
// snn_readout_pkg
// Shared definitions for the SNN readout (spike count classifier) block.
//   - state_e       : controller state encoding
//   - DEF_*         : default parameter values for the readout stage
//   - cnt_sat()     : saturation value of a counter of a given width
// No ports (package).
// -----------------------------------------------------------------------------
package snn_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 6;
    localparam int DEF_WIN_W = 8;

    // All-ones value a CNT_W-wide counter sticks at.
    function automatic int cnt_sat(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// -----------------------------------------------------------------------------
// spike_sat_counter
// One per-neuron spike counter. Synchronous clear has priority over increment;
// the count sticks at its all-ones value instead of wrapping.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low
//   clr_i    in   clear counter to zero
//   inc_i    in   increment by one (saturating)
//   count_o  out  current count
// -----------------------------------------------------------------------------
module spike_sat_counter
    import snn_readout_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != SAT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_count_classifier.sv
// -----------------------------------------------------------------------------
// spike_count_classifier
// Readout stage after the two-layer SNN. Counts output spikes per neuron over a
// window of valid samples, then scans the counts one neuron per cycle and
// reports the most active neuron (lowest index wins ties).
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous reset, active-low
//   start         in   begin a window (accepted in IDLE only)
//   window_len    in   valid samples per window, captured on accepted start
//   spike_in      in   layer-2 spike vector
//   spike_valid   in   spike_in qualifier
//   busy          out  controller not in IDLE
//   class_valid   out  one-cycle pulse when the result outputs update
//   class_id      out  winning neuron index
//   winner_count  out  spike count of the winning neuron
//   no_spike      out  winner_count is zero
//   counts_out    out  live per-neuron counters, neuron i at [i*CNT_W +: CNT_W]
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; counters and results hold
// ACCUM   | counting valid samples until the window is exhausted
// ARGMAX  | sequential scan of counters, one neuron per cycle
// DONE    | final best is stable; results register on the closing edge
// -----------------------------------------------------------------------------
module spike_count_classifier
    import snn_readout_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [N-1:0]         spike_in,
    input  logic                 spike_valid,
    output logic                 busy,
    output logic                 class_valid,
    output logic [$clog2(N)-1:0] class_id,
    output logic [CNT_W-1:0]     winner_count,
    output logic                 no_spike,
    output logic [N*CNT_W-1:0]   counts_out
);

    localparam int               IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e state_q;
    state_e state_d;

    // Control strobes decoded from the state
    logic clr_cnt;
    logic acc_en;
    logic scan_en;
    logic done;

    logic [WIN_W-1:0] remaining_q;
    logic [WIN_W-1:0] remaining_d;
    logic [IDX_W-1:0] scan_idx_q;
    logic [IDX_W-1:0] scan_idx_d;
    logic [IDX_W-1:0] best_idx_q;
    logic [IDX_W-1:0] best_idx_d;
    logic [CNT_W-1:0] best_q;
    logic [CNT_W-1:0] best_d;
    logic [CNT_W-1:0] scan_cnt;

    logic             class_valid_q;
    logic [IDX_W-1:0] class_id_q;
    logic [CNT_W-1:0] winner_count_q;
    logic             no_spike_q;

    logic [CNT_W-1:0] cnt [N];

    // ------------------------------------------------------------------
    // Per-neuron counters
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_cnt
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .clr_i   (clr_cnt),
            .inc_i   (acc_en & spike_in[g]),
            .count_o (cnt[g])
        );
        assign counts_out[g*CNT_W +: CNT_W] = cnt[g];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // An empty window skips straight to the scan of zeroed counters.
                    state_d = (window_len != '0) ? ST_ACCUM : ST_ARGMAX;
                end
            end
            ST_ACCUM: begin
                if (spike_valid && (remaining_q == WIN_W'(1))) begin
                    state_d = ST_ARGMAX;
                end
            end
            ST_ARGMAX: begin
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / control strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != ST_IDLE);
        clr_cnt = (state_q == ST_IDLE) && start;
        acc_en  = (state_q == ST_ACCUM) && spike_valid;
        scan_en = (state_q == ST_ARGMAX);
        done    = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Window counter and argmax scan
    // ------------------------------------------------------------------
    assign scan_cnt = cnt[scan_idx_q];

    always_comb begin
        remaining_d = remaining_q;
        scan_idx_d  = scan_idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;

        if (clr_cnt) begin
            remaining_d = window_len;
            scan_idx_d  = '0;
        end else if (acc_en) begin
            remaining_d = remaining_q - WIN_W'(1);
        end

        if (scan_en) begin
            // Index 0 seeds the running best; strict compare keeps the lowest
            // index on ties.
            if ((scan_idx_q == '0) || (scan_cnt > best_q)) begin
                best_d     = scan_cnt;
                best_idx_d = scan_idx_q;
            end
            scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            scan_idx_q  <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
        end else begin
            remaining_q <= remaining_d;
            scan_idx_q  <= scan_idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded on the edge that leaves DONE, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            class_valid_q  <= 1'b0;
            class_id_q     <= '0;
            winner_count_q <= '0;
            no_spike_q     <= 1'b0;
        end else begin
            class_valid_q <= done;
            if (done) begin
                class_id_q     <= best_idx_q;
                winner_count_q <= best_q;
                no_spike_q     <= (best_q == '0);
            end
        end
    end

    assign class_valid  = class_valid_q;
    assign class_id     = class_id_q;
    assign winner_count = winner_count_q;
    assign no_spike     = no_spike_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
module tb_spike_count_classifier;

    localparam int N   = 8;
    localparam int CW  = 6;
    localparam int WW  = 8;
    localparam int IW  = 3;
    localparam int SAT = 63;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [WW-1:0]     window_len;
    logic [N-1:0]      spike_in;
    logic              spike_valid;
    logic              busy;
    logic              class_valid;
    logic [IW-1:0]     class_id;
    logic [CW-1:0]     winner_count;
    logic              no_spike;
    logic [N*CW-1:0]   counts_out;

    int errors = 0;
    int checks = 0;

    // Stimulus of the current window and reference results
    logic [N-1:0] samp_q[$];
    bit           val_q[$];
    int           exp_cnt[N];
    int           exp_cid;
    int           exp_wc;

    always #5 clk = ~clk;

    spike_count_classifier #(
        .N     (N),
        .CNT_W (CW),
        .WIN_W (WW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .spike_valid  (spike_valid),
        .busy         (busy),
        .class_valid  (class_valid),
        .class_id     (class_id),
        .winner_count (winner_count),
        .no_spike     (no_spike),
        .counts_out   (counts_out)
    );

    // Reference: count the first wl valid samples per neuron with saturation,
    // then pick the highest count, lowest index on ties.
    function automatic void ref_model(input int wl);
        int seen;
        seen = 0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        for (int j = 0; j < samp_q.size(); j++) begin
            if (val_q[j] && seen < wl) begin
                seen++;
                for (int i = 0; i < N; i++)
                    if (samp_q[j][i]) exp_cnt[i] = (exp_cnt[i] + 1 > SAT) ? SAT : exp_cnt[i] + 1;
            end
        end
        exp_cid = 0;
        exp_wc  = exp_cnt[0];
        for (int i = 1; i < N; i++)
            if (exp_cnt[i] > exp_wc) begin
                exp_wc  = exp_cnt[i];
                exp_cid = i;
            end
    endfunction

    function automatic logic [N*CW-1:0] exp_vec();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(exp_cnt[i]);
        return v;
    endfunction

    task automatic push(input logic [N-1:0] s, input bit v);
        samp_q.push_back(s);
        val_q.push_back(v);
    endtask

    task automatic clear_q();
        samp_q.delete();
        val_q.delete();
    endtask

    // Drives one window from the queues (entered and left at posedge+1) and
    // reports what the DUT produced. Latency is counted in edges from the edge
    // that captured the last sample (or the start edge for an empty window).
    task automatic run_window(input int wl, output int lat, output int busy_cyc,
                              output int pulses, output logic [IW-1:0] cid,
                              output logic [CW-1:0] wc, output logic ns,
                              output logic [IW-1:0] cid_pre);
        lat = -1; busy_cyc = 0; pulses = 0; cid = '0; wc = '0; ns = 1'b0;
        start = 1'b1;
        window_len = WW'(wl);
        @(posedge clk); #1;
        start = 1'b0;
        cid_pre = class_id;
        if (busy) busy_cyc++;
        for (int j = 0; j < samp_q.size(); j++) begin
            spike_in = samp_q[j];
            spike_valid = val_q[j];
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (class_valid) pulses++;
        end
        for (int c = 1; c <= 2*N + 8; c++) begin
            spike_in = N'($urandom);
            spike_valid = 1'($urandom);
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (class_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; cid = class_id; wc = winner_count; ns = no_spike;
                end
            end
        end
        spike_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (class_valid !== 1'b0) begin errors++; $display("FAIL reset_class_valid: got %b want 0", class_valid); end
        checks++; if (class_id !== '0) begin errors++; $display("FAIL reset_class_id: got %0d want 0", class_id); end
        checks++; if (winner_count !== '0) begin errors++; $display("FAIL reset_winner_count: got %0d want 0", winner_count); end
        checks++; if (no_spike !== 1'b0) begin errors++; $display("FAIL reset_no_spike: got %b want 0", no_spike); end
        checks++; if (counts_out !== '0) begin errors++; $display("FAIL reset_counts: got %h want 0", counts_out); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_class();
        int lat, bc, pl; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        repeat (4) push(8'b0000_0100, 1'b1);
        ref_model(4);
        run_window(4, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (lat !== N+1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, N+1); end
        checks++; if (pl !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pl); end
        checks++; if (cid !== IW'(exp_cid)) begin errors++; $display("FAIL single_class_id: got %0d want %0d", cid, exp_cid); end
        checks++; if (wc !== CW'(exp_wc)) begin errors++; $display("FAIL single_winner: got %0d want %0d", wc, exp_wc); end
        checks++; if (ns !== 1'b0) begin errors++; $display("FAIL single_no_spike: got %b want 0", ns); end
        checks++; if (bc !== 1 + samp_q.size() + N) begin errors++; $display("FAIL single_busy_cycles: got %0d want %0d", bc, 1 + samp_q.size() + N); end
    endtask

    task automatic test_gap_tie();
        int lat, bc, pl; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        push(8'h81, 1'b1); push(8'hFF, 1'b0); push(8'h80, 1'b1); push(8'hFF, 1'b0); push(8'h01, 1'b1);
        ref_model(3);
        run_window(3, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (counts_out !== exp_vec()) begin errors++; $display("FAIL gap_counts: got %h want %h", counts_out, exp_vec()); end
        checks++; if (cid !== IW'(exp_cid)) begin errors++; $display("FAIL gap_tie_class_id: got %0d want %0d", cid, exp_cid); end
        checks++; if (wc !== CW'(exp_wc)) begin errors++; $display("FAIL gap_winner: got %0d want %0d", wc, exp_wc); end
        checks++; if (lat !== N+1) begin errors++; $display("FAIL gap_latency: got %0d want %0d", lat, N+1); end
    endtask

    task automatic test_saturation();
        int lat, bc, pl; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        repeat (100) push(8'h20, 1'b1);
        ref_model(100);
        run_window(100, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (wc !== CW'(exp_wc)) begin errors++; $display("FAIL sat_winner: got %0d want %0d", wc, exp_wc); end
        checks++; if (cid !== IW'(exp_cid)) begin errors++; $display("FAIL sat_class_id: got %0d want %0d", cid, exp_cid); end
        checks++; if (counts_out !== exp_vec()) begin errors++; $display("FAIL sat_counts: got %h want %h", counts_out, exp_vec()); end
    endtask

    task automatic test_zero_window();
        int lat, bc, pl; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        ref_model(0);
        run_window(0, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (bc !== N+1) begin errors++; $display("FAIL zero_busy_cycles: got %0d want %0d", bc, N+1); end
        checks++; if (lat !== N+1) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, N+1); end
        checks++; if (cid !== '0) begin errors++; $display("FAIL zero_class_id: got %0d want 0", cid); end
        checks++; if (wc !== '0) begin errors++; $display("FAIL zero_winner: got %0d want 0", wc); end
        checks++; if (ns !== 1'b1) begin errors++; $display("FAIL zero_no_spike: got %b want 1", ns); end
        checks++; if (counts_out !== '0) begin errors++; $display("FAIL zero_counts: got %h want 0", counts_out); end
    endtask

    task automatic test_start_ignored_and_reset();
        int lat, bc, pl, pulses; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        repeat (5) push(8'h08, 1'b1);
        ref_model(5);
        pulses = 0; lat = -1; cid = '0; wc = '0;
        start = 1'b1; window_len = 8'd5;
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            start = (j == 1);
            window_len = 8'd2;
            spike_in = 8'h08; spike_valid = 1'b1;
            @(posedge clk); #1;
            if (class_valid) pulses++;
        end
        spike_valid = 1'b0;
        // Pulses land in ARGMAX (2, 5) and in DONE (N+1).
        for (int c = 1; c <= 2*N + 8; c++) begin
            start = (c == 2 || c == 5 || c == N+1);
            window_len = 8'd1;
            @(posedge clk); #1;
            if (class_valid) begin
                pulses++;
                if (lat < 0) begin lat = c; cid = class_id; wc = winner_count; end
            end
        end
        start = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
        checks++; if (lat !== N+1) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat, N+1); end
        checks++; if (cid !== IW'(exp_cid) || wc !== CW'(exp_wc)) begin errors++; $display("FAIL ign_result: got id %0d cnt %0d want id %0d cnt %0d", cid, wc, exp_cid, exp_wc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b want 0", busy); end

        // Mid-window reset
        start = 1'b1; window_len = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            spike_in = 8'hFF; spike_valid = 1'b1;
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || class_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b valid %b want 0 0", busy, class_valid); end
        checks++; if (class_id !== '0 || winner_count !== '0 || no_spike !== 1'b0) begin errors++; $display("FAIL rst_mid_result: got id %0d cnt %0d ns %b want 0 0 0", class_id, winner_count, no_spike); end
        checks++; if (counts_out !== '0) begin errors++; $display("FAIL rst_mid_counts: got %h want 0", counts_out); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            spike_in = N'($urandom); spike_valid = 1'($urandom);
            @(posedge clk); #1;
            if (class_valid || busy) pulses++;
        end
        spike_valid = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", pulses); end

        clear_q();
        push(8'h40, 1'b1); push(8'h40, 1'b1);
        ref_model(2);
        run_window(2, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (cid !== IW'(exp_cid) || wc !== CW'(exp_wc) || pl !== 1) begin errors++; $display("FAIL rst_clean_window: got id %0d cnt %0d pulses %0d want id %0d cnt %0d pulses 1", cid, wc, pl, exp_cid, exp_wc); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, pl; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        clear_q();
        repeat (3) push(8'h10, 1'b1);
        ref_model(3);
        run_window(3, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (cid !== IW'(exp_cid)) begin errors++; $display("FAIL b2b_first_id: got %0d want %0d", cid, exp_cid); end
        clear_q();
        repeat (3) push(8'h02, 1'b1);
        ref_model(3);
        run_window(3, lat, bc, pl, cid, wc, ns, cpre);
        checks++; if (cpre !== 3'd4) begin errors++; $display("FAIL b2b_hold_id: got %0d want 4", cpre); end
        checks++; if (cid !== IW'(exp_cid) || pl !== 1) begin errors++; $display("FAIL b2b_second_id: got %0d pulses %0d want %0d pulses 1", cid, pl, exp_cid); end
    endtask

    task automatic test_random();
        int lat, bc, pl, wl, seen; bit v; logic [IW-1:0] cid, cpre; logic [CW-1:0] wc; logic ns;
        for (int w = 0; w < 8; w++) begin
            clear_q();
            wl = $urandom_range(1, 30);
            seen = 0;
            while (seen < wl) begin
                v = ($urandom_range(0, 3) != 0);
                push(N'($urandom) & N'($urandom), v);
                if (v) seen++;
            end
            ref_model(wl);
            run_window(wl, lat, bc, pl, cid, wc, ns, cpre);
            checks++;
            if (cid !== IW'(exp_cid) || wc !== CW'(exp_wc) || ns !== (exp_wc == 0) || lat !== N+1 || pl !== 1) begin
                errors++;
                $display("FAIL rand_win%0d: got id %0d cnt %0d ns %b lat %0d pulses %0d want id %0d cnt %0d lat %0d pulses 1",
                         w, cid, wc, ns, lat, pl, exp_cid, exp_wc, N+1);
            end
            checks++; if (counts_out !== exp_vec()) begin errors++; $display("FAIL rand_counts%0d: got %h want %h", w, counts_out, exp_vec()); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        window_len = '0;
        spike_in = '0;
        spike_valid = 1'b0;
        test_reset();
        test_single_class();
        test_gap_tie();
        test_saturation();
        test_zero_window();
        test_start_ignored_and_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
